gpr_port_sched: RTL and testbench
=================================

// Module: gpr_port_sched
// PURPOSE
//  Owns both ports of gpr_regfile (1 write, 1 read, 2-cycle read latency).
//  After reset, it sweeps the register file to zero. It then shares the read
//  port among NREQ operand-fetch requesters using round-robin arbitration, and
//  the write port between load-return and ALU writeback using fixed priority.
//  It forwards a write that collides with an in-flight read, so requesters
//  always see the latest value. Sits between the thread issue stage and the
//  regfile instance.
// PARAMETERS
//  NREQ   4  number of read requesters (>=2); TW = $clog2(NREQ)
//  NENT   NTHREADS*NREGS  regfile entries to clear; from rfPhoenixPkg
// PORTS
//  clk        in   1      clock; all state on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  rreq       in   NREQ   read request per requester; held until granted
//  raddr      in   NREQ*AW  per-requester address {tid,reg}; AW = TidMSB+7
//  rgnt       out  NREQ   one-hot grant; raddr sampled in the grant cycle
//  rvalid     out  1      read data valid, 2 cycles after grant
//  rtag       out  TW     index of the requester that owns rdata
//  rdata      out  32     read data (Value), forwarded if needed
//  ld_req/ld_addr/ld_data   in  1/AW/32  load-return write request
//  wb_req/wb_addr/wb_data   in  1/AW/32  ALU writeback write request
//  ld_gnt, wb_gnt  out  1  write accepted this cycle
//  rf_wr, rf_wa, rf_i   out  1/AW/32  to regfile write port
//  rf_ra      out  AW     to regfile read port
//  rf_o       in   32     from regfile
//  busy       out  1      clear sweep in progress
// BEHAVIOUR
//  Reset (async, any time): state=CLEAR, clr_cnt=0, rr pointer=0, pipe valids=0,
//   bypass valid=0. Outputs: rgnt=0, rvalid=0, rtag=0, ld_gnt=wb_gnt=0, busy=1,
//   rf_wr=0, rf_wa=0, rf_i=0, rf_ra=0.
//   Reset mid-operation drops in-flight reads (no rvalid) and restarts the sweep.
//  FSM CLEAR: first cycle after rst_n deasserts, rf_wr=1, rf_wa=clr_cnt, rf_i=0,
//   clr_cnt++. The cycle that writes NENT-1 is the last CLEAR cycle; next -> RUN.
//   No grants in CLEAR; busy=1. Sweep takes exactly NENT cycles.
//  FSM RUN: busy=0; stays in RUN until reset.
//  Write arbitration (combinational, same cycle): ld_req wins over wb_req.
//   Winner: gnt=1, rf_wr=1, rf_wa/rf_i=winner. Loser holds its request.
//   No request -> rf_wr=0.
//  Read arbitration: round-robin among rreq, starting at ptr.
//   Winner k: rgnt[k]=1, rf_ra=raddr[k]. ptr<=k+1 (mod NREQ).
//   No request -> ptr unchanged, rf_ra holds its last value.
//  Read pipe: grant in cycle N -> s1 (valid, tag, addr) at N+1 -> s2 at N+2.
//   At N+2: rvalid=s2.v, rtag=s2.tag, rdata=rf_o unless bypass hit.
//  Bypass: a regfile write in cycle N+1 commits on the same edge the regfile
//   reads rar, so the regfile returns the stale value.
//   Capture (rf_wr,rf_wa,rf_i) each cycle into byp.
//   In N+2: if byp.v && byp.wa==s2.addr -> rdata=byp.data.
//   Writes in cycle <=N are visible natively; no forwarding needed.
//  Same-cycle read and write to the same address in cycle N: the regfile
//   returns the new value (write is at or before N). No bypass needed.
//  One read grant per cycle max; throughput 1 read/cycle; rvalid may be
//   asserted on consecutive cycles.
// STRUCTURE
//  rfPhoenixPkg: add typedef RegAddr (logic [TidMSB+6:0]) and
//   typedef enum {CLEAR,RUN} gpr_sched_st_e. Value, NTHREADS, NREGS and TidMSB
//   already live there.
//  Sub-module gpr_rr_arb (NREQ, req, ptr -> one-hot gnt, idx) for the read
//   arbiter. Write arbiter, FSM, pipe and bypass stay inline.
// TESTING (bench pairs with real gpr_regfile, NTHREADS=4, NREGS=64)
//  1 Reset release -> busy=1 for exactly 256 cycles, rf_wr=1 with rf_wa 0..255
//    and rf_i=0; then busy=0. Read of any address -> rdata=0.
//  2 wb write addr 0x045=0xDEADBEEF at T, read req0 0x045 at T+1 -> rvalid at
//    T+3, rtag=0, rdata=0xDEADBEEF.
//  3 Bypass: grant read of 0x010 at N, ld write 0x010=0x12345678 at N+1 ->
//    rdata at N+2 = 0x12345678. Same with write at N+2 -> old value.
//  4 All four rreq held high 8 cycles -> grant order 0,1,2,3,0,1,2,3.
//    rvalid high 8 consecutive cycles with matching rtag.
//  5 ld_req and wb_req together -> ld_gnt=1, wb_gnt=0. Next cycle wb_gnt=1.
//    Both values land in the regfile.
//  6 rst_n pulsed low with 2 reads in flight -> rvalid stays 0, outputs reset
//    immediately, clear sweep restarts from addr 0.

Source files
------------

// File: rtl/gpr_port_sched_pkg.sv
// Shared types and sizing for the GPR port scheduler.
package gpr_port_sched_pkg;

   localparam int NTHREADS = 4;
   localparam int NREGS    = 64;
   localparam int TidMSB   = $clog2(NTHREADS) - 1;
   localparam int AW       = TidMSB + 7;
   localparam int NENT_DEF = NTHREADS * NREGS;

   typedef logic [31:0]       Value;
   typedef logic [TidMSB+6:0] RegAddr;

   typedef enum logic {CLEAR, RUN} gpr_sched_st_e;

   // One regfile write as seen on the write port.
   typedef struct packed {
      logic   v;
      RegAddr wa;
      Value   data;
   } wr_s;

endpackage

// File: rtl/gpr_port_sched_rr_arb.sv
// Round-robin read-port arbiter: searches req starting at ptr, wrapping.
module gpr_rr_arb #(
   parameter  int NREQ = 4,
   localparam int TW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [TW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [TW-1:0]   idx,
   output logic            any
);

   // First requester at or after ptr wins.
   always_comb begin : pick
      int k;
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = 0;
      for (int i = 0; i < NREQ; i++) begin
         k = (int'(ptr) + i) % NREQ;
         if (!any && req[k]) begin
            any    = 1'b1;
            idx    = TW'(k);
            gnt[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpr_port_sched.sv
// Owns the regfile ports: clear sweep after reset, round-robin reads with a
// two-stage pipe plus write forwarding, fixed-priority writes (load first).
module gpr_port_sched
   import gpr_port_sched_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int NENT = NENT_DEF,
   localparam int TW   = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    rreq,
   input  logic [NREQ*AW-1:0] raddr,
   output logic [NREQ-1:0]    rgnt,
   output logic               rvalid,
   output logic [TW-1:0]      rtag,
   output logic [31:0]        rdata,
   input  logic               ld_req,
   input  logic [AW-1:0]      ld_addr,
   input  logic [31:0]        ld_data,
   input  logic               wb_req,
   input  logic [AW-1:0]      wb_addr,
   input  logic [31:0]        wb_data,
   output logic               ld_gnt,
   output logic               wb_gnt,
   output logic               rf_wr,
   output logic [AW-1:0]      rf_wa,
   output logic [31:0]        rf_i,
   output logic [AW-1:0]      rf_ra,
   input  logic [31:0]        rf_o,
   output logic               busy
);

   typedef struct packed {
      logic          v;
      logic [TW-1:0] tag;
      RegAddr        addr;
   } rd_stage_s;

   gpr_sched_st_e   state, state_nxt;
   RegAddr          clr_cnt;
   logic            clr_last;
   logic            run;
   logic [TW-1:0]   ptr;
   RegAddr          ra_hold;
   rd_stage_s       s1, s2;
   wr_s             byp;
   logic [NREQ-1:0] arb_gnt;
   logic [TW-1:0]   arb_idx;
   logic            arb_any;
   logic            grant;

   assign run      = (state == RUN);
   assign busy     = !run;
   assign clr_last = (clr_cnt == RegAddr'(NENT - 1));

   // State register and sweep address counter.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_cnt <= clr_cnt + RegAddr'(1);
      end
   end

   // Next state: leave CLEAR after the cycle that writes the last entry.
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_last) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   // Write port: sweep zeros in CLEAR, else load beats ALU writeback.
   always_comb begin
      ld_gnt = 1'b0;
      wb_gnt = 1'b0;
      rf_wr  = 1'b0;
      rf_wa  = '0;
      rf_i   = '0;
      if (!run) begin
         // Gated by rst_n so the port stays quiet while reset is held.
         rf_wr = rst_n;
         rf_wa = clr_cnt;
      end else if (ld_req) begin
         ld_gnt = 1'b1;
         rf_wr  = 1'b1;
         rf_wa  = ld_addr;
         rf_i   = ld_data;
      end else if (wb_req) begin
         wb_gnt = 1'b1;
         rf_wr  = 1'b1;
         rf_wa  = wb_addr;
         rf_i   = wb_data;
      end
   end

   gpr_rr_arb #(.NREQ(NREQ)) u_arb (
      .req (rreq),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign grant = run && arb_any;
   assign rgnt  = run ? arb_gnt : '0;
   assign rf_ra = grant ? raddr[arb_idx*AW +: AW] : ra_hold;

   // Round-robin pointer, held read address, read pipe and write capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= '0;
         ra_hold <= '0;
         s1      <= '0;
         s2      <= '0;
         byp     <= '0;
      end else begin
         if (grant) ptr <= (arb_idx == TW'(NREQ - 1)) ? '0 : arb_idx + TW'(1);
         ra_hold <= rf_ra;
         s1      <= '{v: grant, tag: arb_idx, addr: rf_ra};
         s2      <= s1;
         byp     <= '{v: rf_wr, wa: rf_wa, data: rf_i};
      end
   end

   // A write one cycle after the grant lands too late for the regfile read; forward it.
   always_comb begin
      rvalid = s2.v;
      rtag   = s2.tag;
      rdata  = (byp.v && byp.wa == s2.addr) ? byp.data : rf_o;
   end

endmodule

// File: tb/tb_gpr_port_sched.sv
// Directed bench for gpr_port_sched with a behavioural 2-cycle regfile.
module tb_gpr_port_sched;
   import gpr_port_sched_pkg::*;

   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   rreq;
   logic [NREQ*AW-1:0] raddr;
   logic [NREQ-1:0]   rgnt;
   logic              rvalid;
   logic [1:0]        rtag;
   logic [31:0]       rdata;
   logic              ld_req, wb_req, ld_gnt, wb_gnt;
   logic [AW-1:0]     ld_addr, wb_addr;
   logic [31:0]       ld_data, wb_data;
   logic              rf_wr;
   logic [AW-1:0]     rf_wa, rf_ra;
   logic [31:0]       rf_i, rf_o;
   logic              busy;
   logic [AW-1:0]     ra [NREQ];

   assign raddr = {ra[3], ra[2], ra[1], ra[0]};

   always #5 clk = ~clk;

   gpr_port_sched #(.NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n), .rreq(rreq), .raddr(raddr), .rgnt(rgnt),
      .rvalid(rvalid), .rtag(rtag), .rdata(rdata),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
      .ld_gnt(ld_gnt), .wb_gnt(wb_gnt), .rf_wr(rf_wr), .rf_wa(rf_wa),
      .rf_i(rf_i), .rf_ra(rf_ra), .rf_o(rf_o), .busy(busy)
   );

   // Regfile: write commits on the edge; read address registered, data one edge later.
   logic [31:0]   mem [256];
   logic [AW-1:0] rar;
   always @(posedge clk) begin
      if (rf_wr) mem[rf_wa] <= rf_i;
      rar  <= rf_ra;
      rf_o <= mem[rar];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rreq   = '0;
      ld_req = 1'b0;
      wb_req = 1'b0;
   endtask

   // Grant one read, then expect its result two cycles later.
   task automatic do_read(input int k, input logic [AW-1:0] a, input logic [31:0] exp, input string name);
      logic [3:0] oh;
      oh = 4'b0001 << k;
      tick(); idle(); rreq = oh; ra[k] = a; #1;
      check({name, "_rgnt"}, rgnt, oh);
      check({name, "_rfra"}, rf_ra, a);
      tick(); idle(); #1;
      check({name, "_rv_early"}, rvalid, 0);
      tick(); idle(); #1;
      check({name, "_rvalid"}, rvalid, 1);
      check({name, "_rtag"}, rtag, k);
      check({name, "_rdata"}, rdata, exp);
   endtask

   typedef struct {
      logic       ld, wb;
      logic [3:0] rq;
      logic       e_ld, e_wb;
      logic [3:0] e_gnt;
      logic       e_rv;
      logic [1:0] e_tag;
   } vec_t;

   vec_t vecs [16];

   initial begin
      // ld, wb, rreq, exp ld_gnt, wb_gnt, rgnt, rvalid, rtag  (ptr starts at 0)
      vecs[0]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0};
      vecs[1]  = '{1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0};
      vecs[2]  = '{1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd0};
      vecs[3]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd1};
      vecs[4]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd2};
      vecs[5]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd3};
      vecs[6]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd0};
      vecs[7]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd1};
      vecs[8]  = '{1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd2};
      vecs[9]  = '{1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3};
      vecs[10] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
      vecs[11] = '{1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd3};
      vecs[12] = '{1'b0, 1'b0, 4'b1001, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd0};
      vecs[13] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
      vecs[14] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3};
      vecs[15] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};

      // Reset held, requests active: nothing may be granted.
      for (int k = 0; k < NREQ; k++) ra[k] = '0;
      rreq = 4'b1111; ld_req = 1'b1; wb_req = 1'b1;
      ld_addr = 8'h45; ld_data = 32'hFFFF_FFFF;
      wb_addr = 8'h46; wb_data = 32'hEEEE_EEEE;
      #2;
      check("rst_busy", busy, 1);
      check("rst_rf_wr", rf_wr, 0);
      check("rst_rf_wa", rf_wa, 0);
      check("rst_rf_i", rf_i, 0);
      check("rst_rf_ra", rf_ra, 0);
      check("rst_rgnt", rgnt, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rtag", rtag, 0);
      check("rst_ld_gnt", ld_gnt, 0);
      check("rst_wb_gnt", wb_gnt, 0);

      // Release mid-cycle; sweep must take exactly 256 cycles.
      @(posedge clk); #2;
      rst_n = 1'b1; #1;
      for (int i = 0; i < 256; i++) begin
         check("clr_busy", busy, 1);
         check("clr_rf_wr", rf_wr, 1);
         check("clr_rf_wa", rf_wa, i);
         check("clr_rf_i", rf_i, 0);
         check("clr_no_gnt", {rgnt, ld_gnt, wb_gnt}, 0);
         tick();
      end
      idle(); #1;
      check("run_busy", busy, 0);
      check("run_rf_wr_idle", rf_wr, 0);

      // Cleared entries read back as zero.
      do_read(2, 8'h80, 32'h0, "clr_rd80");
      do_read(3, 8'hFF, 32'h0, "clr_rdFF");

      // Write then read the next cycle.
      tick(); idle(); wb_req = 1'b1; wb_addr = 8'h45; wb_data = 32'hDEAD_BEEF; #1;
      check("wb_gnt", wb_gnt, 1);
      check("wb_ld_gnt", ld_gnt, 0);
      check("wb_rf_wa", rf_wa, 8'h45);
      check("wb_rf_i", rf_i, 32'hDEAD_BEEF);
      do_read(0, 8'h45, 32'hDEAD_BEEF, "wr_rd45");

      // Write one cycle after the grant must be forwarded.
      tick(); idle(); rreq = 4'b0010; ra[1] = 8'h10; #1;
      check("byp_rgnt", rgnt, 4'b0010);
      tick(); idle(); ld_req = 1'b1; ld_addr = 8'h10; ld_data = 32'h1234_5678; #1;
      check("byp_ld_gnt", ld_gnt, 1);
      tick(); idle(); #1;
      check("byp_rvalid", rvalid, 1);
      check("byp_rtag", rtag, 1);
      check("byp_rdata", rdata, 32'h1234_5678);

      // Write two cycles after the grant: reader sees the old value.
      tick(); idle(); rreq = 4'b0100; ra[2] = 8'h10; #1;
      check("late_rgnt", rgnt, 4'b0100);
      tick(); idle(); #1;
      tick(); idle(); ld_req = 1'b1; ld_addr = 8'h10; ld_data = 32'hCAFE_F00D; #1;
      check("late_rvalid", rvalid, 1);
      check("late_rtag", rtag, 2);
      check("late_rdata_old", rdata, 32'h1234_5678);

      // Same-cycle read and write of one address returns the new value.
      tick(); idle(); rreq = 4'b1000; ra[3] = 8'h20;
      wb_req = 1'b1; wb_addr = 8'h20; wb_data = 32'h0BAD_F00D; #1;
      check("same_rgnt", rgnt, 4'b1000);
      check("same_wb_gnt", wb_gnt, 1);
      tick(); idle(); #1;
      tick(); idle(); #1;
      check("same_rvalid", rvalid, 1);
      check("same_rdata", rdata, 32'h0BAD_F00D);

      // Write to a different address one cycle after grant: no forwarding.
      tick(); idle(); rreq = 4'b1000; ra[3] = 8'h30; #1;
      check("miss_rgnt", rgnt, 4'b1000);
      tick(); idle(); ld_req = 1'b1; ld_addr = 8'h31; ld_data = 32'h5555_5555; #1;
      tick(); idle(); #1;
      check("miss_rvalid", rvalid, 1);
      check("miss_rdata", rdata, 32'h0);
      do_read(3, 8'h10, 32'hCAFE_F00D, "late_landed");

      // Table: round-robin order, back-to-back rvalid, write priority.
      for (int k = 0; k < NREQ; k++) ra[k] = AW'(8'h70 + k);
      ld_addr = 8'h60; wb_addr = 8'h61;
      for (int i = 0; i < 16; i++) begin
         tick(); idle();
         rreq = vecs[i].rq; ld_req = vecs[i].ld; wb_req = vecs[i].wb;
         ld_data = 32'(i); wb_data = 32'(i + 100);
         #1;
         check($sformatf("v%0d_ld_gnt", i), ld_gnt, vecs[i].e_ld);
         check($sformatf("v%0d_wb_gnt", i), wb_gnt, vecs[i].e_wb);
         check($sformatf("v%0d_rf_wr", i), rf_wr, vecs[i].e_ld | vecs[i].e_wb);
         check($sformatf("v%0d_rgnt", i), rgnt, vecs[i].e_gnt);
         check($sformatf("v%0d_rvalid", i), rvalid, vecs[i].e_rv);
         if (vecs[i].e_rv) begin
            check($sformatf("v%0d_rtag", i), rtag, vecs[i].e_tag);
            check($sformatf("v%0d_rdata", i), rdata, 32'h0);
         end
      end

      // Load and writeback together: load first, writeback next cycle.
      tick(); idle();
      ld_req = 1'b1; ld_addr = 8'h90; ld_data = 32'h1111_1111;
      wb_req = 1'b1; wb_addr = 8'h91; wb_data = 32'h2222_2222; #1;
      check("both_ld_gnt", ld_gnt, 1);
      check("both_wb_gnt", wb_gnt, 0);
      check("both_rf_wa", rf_wa, 8'h90);
      check("both_rf_i", rf_i, 32'h1111_1111);
      tick(); idle(); wb_req = 1'b1; #1;
      check("held_wb_gnt", wb_gnt, 1);
      check("held_rf_wa", rf_wa, 8'h91);
      tick(); idle(); rreq = 4'b0011; ra[0] = 8'h90; ra[1] = 8'h91; #1;
      check("both_rd_gnt0", rgnt, 4'b0001);
      tick(); idle(); rreq = 4'b0010; #1;
      check("both_rd_gnt1", rgnt, 4'b0010);
      tick(); idle(); #1;
      check("both_rd0_tag", rtag, 0);
      check("both_rd0_data", rdata, 32'h1111_1111);
      tick(); idle(); #1;
      check("both_rd1_tag", rtag, 1);
      check("both_rd1_data", rdata, 32'h2222_2222);

      // Reset with reads in flight: ptr is 2 here.
      tick(); idle(); rreq = 4'b0011; ra[0] = 8'h45; #1;
      check("fl_gnt0", rgnt, 4'b0001);
      tick(); idle(); rreq = 4'b0010; #1;
      check("fl_gnt1", rgnt, 4'b0010);
      #1; rst_n = 1'b0; #1;
      check("mid_rst_busy", busy, 1);
      check("mid_rst_rgnt", rgnt, 0);
      check("mid_rst_rf_wr", rf_wr, 0);
      check("mid_rst_rf_ra", rf_ra, 0);
      check("mid_rst_rvalid", rvalid, 0);
      for (int i = 0; i < 2; i++) begin
         tick(); #1;
         check("mid_rst_rvalid_hold", rvalid, 0);
      end
      idle(); #1;
      rst_n = 1'b1; #1;
      for (int i = 0; i < 256; i++) begin
         check("reclr_busy", busy, 1);
         check("reclr_rf_wa", rf_wa, i);
         check("reclr_rvalid", rvalid, 0);
         tick();
      end
      idle(); #1;
      check("reclr_done", busy, 0);

      // Pointer restarted at 0: requester 1 wins over 2; entry was cleared.
      rreq = 4'b0110; ra[1] = 8'h45; ra[2] = 8'h91; #1;
      check("post_rst_gnt", rgnt, 4'b0010);
      tick(); idle(); #1;
      tick(); idle(); #1;
      check("post_rst_rvalid", rvalid, 1);
      check("post_rst_rtag", rtag, 1);
      check("post_rst_rdata", rdata, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
